// File: rtl/rsadd_rnd_seq.sv
// Multi-cycle right-shift / guard-round-sticky / IEEE rounding sequencer for the FPU mantissa adder path.
// Optional feature macro: FPU_RND_DIRECTED_EN enables the RP/RM directed rounding modes.
module rsadd_rnd_seq #(
    parameter int FRAC_W  = 52,
    parameter int STEP    = 8,
    parameter int SHAMT_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fpuhold,
    input  logic               start,
    input  logic [FRAC_W:0]    mant_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               stin,
    input  logic               sign,
    input  logic [1:0]         rnd_mode,
    output logic               busy,
    output logic               done,
    output logic [FRAC_W:0]    mant_out,
    output logic               rnd_cout,
    output logic               inexact,
    output logic               rnd_inc
);

    localparam int AW    = FRAC_W + 3;
    localparam int REM_W = $clog2(AW + 1);

`ifdef FPU_RND_DIRECTED_EN
    localparam logic DIRECTED = 1'b1;
`else
    localparam logic DIRECTED = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic               sticky_q, sticky_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [1:0]         mode_q, mode_d;
    logic               sign_q, sign_d;
    logic [FRAC_W:0]    mant_q, mant_d;
    logic               cout_q, cout_d;
    logic               inexact_q, inexact_d;
    logic               inc_q, inc_d;

    logic [REM_W-1:0]   k;
    logic [REM_W-1:0]   rem_load;
    logic [AW-1:0]      lost_mask;
    logic [1:0]         mode_eff;
    logic               grs;
    logic               inc;
    logic               load;
    logic [FRAC_W+1:0]  sum;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        rem_d     = rem_q;
        mode_d    = mode_q;
        sign_d    = sign_q;
        mant_d    = mant_q;
        cout_d    = cout_q;
        inexact_d = inexact_q;
        inc_d     = inc_q;

        k         = (rem_q > REM_W'(STEP)) ? REM_W'(STEP) : rem_q;
        lost_mask = ~({AW{1'b1}} << k);
        rem_load  = (32'(shamt) >= 32'(AW)) ? REM_W'(AW) : REM_W'(shamt);
        load      = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        // Without directed rounding, modes 2/3 fold onto RNE/RZ.
        mode_eff  = {mode_q[1] & DIRECTED, mode_q[0]};
        grs       = acc_q[1] | acc_q[0] | sticky_q;
        case (mode_eff)
            2'd0:    inc = acc_q[1] & (acc_q[0] | sticky_q | acc_q[2]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = ~sign_q & grs;
            default: inc = sign_q & grs;
        endcase
        sum = {1'b0, acc_q[AW-1:2]} + {{(FRAC_W+1){1'b0}}, inc};

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (load) begin
                    acc_d    = {mant_in, 2'b00};
                    sticky_d = stin;
                    rem_d    = rem_load;
                    mode_d   = rnd_mode;
                    sign_d   = sign;
                    state_d  = (rem_load != '0) ? S_SHIFT : S_ROUND;
                end
            end
            S_SHIFT: begin
                acc_d    = acc_q >> k;
                sticky_d = sticky_q | (|(acc_q & lost_mask));
                rem_d    = rem_q - k;
                if (rem_q == k) state_d = S_ROUND;
            end
            S_ROUND: begin
                mant_d    = sum[FRAC_W:0];
                cout_d    = sum[FRAC_W+1];
                inexact_d = grs;
                inc_d     = inc;
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            rem_q     <= '0;
            mode_q    <= '0;
            sign_q    <= 1'b0;
            mant_q    <= '0;
            cout_q    <= 1'b0;
            inexact_q <= 1'b0;
            inc_q     <= 1'b0;
        end else if (!fpuhold) begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            rem_q     <= rem_d;
            mode_q    <= mode_d;
            sign_q    <= sign_d;
            mant_q    <= mant_d;
            cout_q    <= cout_d;
            inexact_q <= inexact_d;
            inc_q     <= inc_d;
        end
    end

    assign busy     = (state_q == S_SHIFT) || (state_q == S_ROUND);
    assign done     = (state_q == S_DONE);
    assign mant_out = mant_q;
    assign rnd_cout = cout_q;
    assign inexact  = inexact_q;
    assign rnd_inc  = inc_q;

endmodule
